// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_top TX FIFO write port among N_REQ byte streams.
// Optional per-grant header byte (8'hC0 | owner index) when UART_ARB_HDR_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_write_en,
  input  logic               i_tx_full,
  output logic               o_busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  logic [N_REQ-1:0] gnt_oh;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [IW:0]      rr_sum;

  // Route the current owner's stream onto the shared path.
  always_comb begin
    gnt_oh    = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx_q == IW'(k)) begin
        gnt_oh[k] = 1'b1;
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[8*k +: 8];
      end
    end
  end

  // Scan from the farthest offset down so the nearest valid requester at/after ptr wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(N_REQ)) rr_sum = rr_sum - (IW+1)'(N_REQ);
      if (i_req_valid[rr_sum[IW-1:0]]) begin
        pick_idx = rr_sum[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

`ifdef UART_ARB_HDR_EN
  logic [2:0] hdr_idx;
  assign hdr_idx = 3'(gidx_q);
`endif

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CW'(1);
    o_req_ready   = '0;
    o_grant       = '0;
    o_tx_data     = '0;
    o_tx_write_en = 1'b0;
    o_busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d = pick_idx;
`ifdef UART_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        o_grant = gnt_oh;
        if (!i_tx_full) begin
          o_tx_write_en = 1'b1;
          o_tx_data     = 8'hC0 | {5'b0, hdr_idx};
          state_d       = XFER;
        end
      end
`endif
      XFER: begin
        o_grant = gnt_oh;
        if (!i_tx_full) o_req_ready = gnt_oh;
        if (sel_valid && !i_tx_full) begin
          o_tx_write_en = 1'b1;
          o_tx_data     = sel_data;
          // Release on end of packet or when the burst cap is reached.
          if (sel_last || cnt_inc == CW'(MAX_BURST)) begin
            ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues feed the DUT, a packet-level
// round-robin model predicts the FIFO write stream (with headers when UART_ARB_HDR_EN is defined).
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0]   req_data;
  logic [7:0]        tx_data;
  logic              tx_we, tx_full, busy;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N_REQ(NR), .MAX_BURST(MB)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_grant      (grant),
    .o_tx_data    (tx_data),
    .o_tx_write_en(tx_we),
    .i_tx_full    (tx_full),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Per-requester byte queues: {last, data}
  logic [8:0]    mem [NR][256];
  int            head [NR];
  int            tail [NR];
  int            m_ptr;
  logic [7:0]    exp_d [1024];
  int            exp_g [1024];
  int            exp_n;
  logic [7:0]    obs_d [1024];
  logic [NR-1:0] obs_g [1024];
  int            obs_n;
  int            seg_cnt;
  bit            expect_idle;
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input bit last);
    mem[k][tail[k]] = {last, d};
    tail[k]++;
  endtask

  task automatic flush();
    for (int k = 0; k < NR; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (head[k] < tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input int c, input int mode);
    case (mode)
      1:       tx_full = ($urandom_range(0, 3) == 0);
      2:       tx_full = (c >= 3 && c < 8);
      default: tx_full = 1'b0;
    endcase
    for (int k = 0; k < NR; k++) begin
      if (head[k] < tail[k]) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = mem[k][head[k]][7:0];
        req_last[k]        = mem[k][head[k]][8];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
  endtask

  // Packet-level model: serve queued packets round-robin, at most MB bytes per grant.
  task automatic model_expect();
    int         h [NR];
    int         g;
    int         n;
    bit         done;
    logic [8:0] e;
    exp_n = 0;
    for (int k = 0; k < NR; k++) h[k] = head[k];
    forever begin
      g = -1;
      for (int i = 0; i < NR; i++)
        if (g < 0 && h[(m_ptr + i) % NR] < tail[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
      if (g < 0) break;
`ifdef UART_ARB_HDR_EN
      exp_d[exp_n] = 8'hC0 | 8'(g);
      exp_g[exp_n] = g;
      exp_n++;
`endif
      n    = 0;
      done = 1'b0;
      while (!done && h[g] < tail[g]) begin
        e = mem[g][h[g]];
        h[g]++;
        exp_d[exp_n] = e[7:0];
        exp_g[exp_n] = g;
        exp_n++;
        n++;
        done = e[8] || (n == MB);
      end
      m_ptr = (g + 1) % NR;
    end
  endtask

  task automatic sample();
    if (expect_idle) begin
      check("idle_after_release_busy", 32'(busy), 32'(0));
      check("idle_after_release_grant", 32'(grant), 32'(0));
    end
    expect_idle = 1'b0;
    check("grant_onehot0", 32'($onehot0(grant)), 32'(1));
    check("busy_vs_grant", 32'(busy), 32'(grant != '0));
    check("no_write_when_full", 32'(tx_we & tx_full), 32'(0));
    check("ready_only_granted", 32'(req_ready & ~grant), 32'(0));
    check("no_ready_when_full", 32'(req_ready & {NR{tx_full}}), 32'(0));
`ifndef UART_ARB_HDR_EN
    check("ready_is_grant", 32'(req_ready), 32'(tx_full ? '0 : grant));
`endif
    if (!tx_we) check("data_zero_no_write", 32'(tx_data), 32'(0));
    if (prev_grant != '0 && grant != '0) check("grant_no_switch", 32'(grant), 32'(prev_grant));
    prev_grant = grant;
    acc = req_valid & req_ready;
    if (tx_we && obs_n < 1024) begin
      obs_d[obs_n] = tx_data;
      obs_g[obs_n] = grant;
      obs_n++;
    end
    if (acc != '0) begin
      seg_cnt++;
      if ((req_last & acc) != '0 || seg_cnt == MB) begin
        expect_idle = 1'b1;
        seg_cnt     = 0;
      end
    end
  endtask

  task automatic run(input int mode, input int maxc, input bit need_done);
    int c  = 0;
    int tc = -1;
    obs_n = 0;
    drive(c, mode);
    while (c < maxc && tc != 0) begin
      @(negedge clk);
      sample();
      if (mode == 2 && c == 8) check("resume_on_full_drop", 32'(tx_we), 32'(1));
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (acc[k]) head[k]++;
      c++;
      if (tc > 0) tc--;
      else if (tc < 0 && need_done && all_empty()) tc = 2;
      drive(c, mode);
    end
    if (need_done) check("run_within_budget", 32'(tc == 0), 32'(1));
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, 32'(obs_n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < obs_n; i++) begin
      check({tag, "_data"}, 32'(obs_d[i]), 32'(exp_d[i]));
      check({tag, "_grant"}, 32'(obs_g[i]), 32'(1) << exp_g[i]);
    end
  endtask

  initial begin
    int npk;
    int len;
    rst_n       = 1'b0;
    tx_full     = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    flush();
    m_ptr       = 0;
    seg_cnt     = 0;
    expect_idle = 1'b0;
    prev_grant  = '0;
    acc         = '0;
    #12;
    check("reset_grant", 32'(grant), 32'(0));
    check("reset_ready", 32'(req_ready), 32'(0));
    check("reset_we", 32'(tx_we), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_data", 32'(tx_data), 32'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two rounds of 1-byte packets from every requester
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) push(k, 8'(16 * (r + 1) + k), 1'b1);
    model_expect();
    run(0, 200, 1'b1);
    compare_log("round_robin");

    // Requester 1: 0x11 0x22 0x33
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    model_expect();
    run(0, 100, 1'b1);
    compare_log("single_pkt");

    // Requester 2: 20-byte packet split by the burst cap, requester 3 in between
    for (int i = 0; i < 20; i++) push(2, 8'(i + 1), i == 19);
    for (int i = 0; i < 3; i++) push(3, 8'(8'hB0 + i), i == 2);
    model_expect();
    run(0, 300, 1'b1);
    compare_log("burst_cap");

    // FIFO full for 5 cycles mid-packet
    for (int i = 0; i < 8; i++) push(1, 8'(8'h60 + i), i == 7);
    model_expect();
    run(2, 200, 1'b1);
    compare_log("full_stall");

    // Reset in the middle of a requester-2 packet
    for (int i = 0; i < 10; i++) push(2, 8'(8'h70 + i), i == 9);
    run(0, 4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'(0));
    check("async_rst_ready", 32'(req_ready), 32'(0));
    check("async_rst_we", 32'(tx_we), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_data", 32'(tx_data), 32'(0));
    flush();
    drive(0, 0);
    m_ptr       = 0;
    seg_cnt     = 0;
    expect_idle = 1'b0;
    prev_grant  = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 8'h01, 1'b1);
    push(2, 8'h02, 1'b1);
    model_expect();
    run(0, 100, 1'b1);
    compare_log("post_reset");

    // Randomized packets with random FIFO backpressure
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NR; k++) begin
        if (k == 0 || $urandom_range(0, 3) != 0) begin
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) push(k, 8'($urandom), i == len - 1);
          end
        end
      end
      model_expect();
      run(1, 3000, 1'b1);
      compare_log("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
